// File: rtl/fir_ram_pkg.sv
// fir_ram_pkg: loader state type, error codes and shared defaults for the coefficient loader
package fir_ram_pkg;
  typedef enum logic [2:0] {IDLE, PAYLOAD, CSUM, DONE, ERROR} load_state_e;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hC5;
  function automatic int bytes_per_coef(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/fir_coef_assembler.sv
// fir_coef_assembler: gathers LSB-first bytes into one coefficient word, pulsing word_val_o on the last byte
module fir_coef_assembler import fir_ram_pkg::*; #(
  parameter int COEF_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  byte_val_i,
  input  logic [7:0]            byte_i,
  output logic                  word_val_o,
  output logic [COEF_WIDTH-1:0] word_o
);
  localparam int BPC = bytes_per_coef(COEF_WIDTH);
  localparam int IW = BPC > 1 ? $clog2(BPC) : 1;
  logic [IW-1:0] idx_q, idx_d;
  logic [BPC*8-1:0] buf_q, buf_d;
  always_comb begin
    buf_d = buf_q;
    for (int b = 0; b < BPC; b++)
      buf_d[b*8 +: 8] = (byte_val_i && idx_q == IW'(b)) ? byte_i : buf_q[b*8 +: 8];
    word_val_o = byte_val_i && idx_q == IW'(BPC - 1);
    idx_d = clr_i ? '0 : !byte_val_i ? idx_q : word_val_o ? '0 : idx_q + 1'b1;
    word_o = buf_d[COEF_WIDTH-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: parses framed, checksummed coefficient sets from a byte stream into RAM writes
module fir_coef_loader import fir_ram_pkg::*; #(
  parameter int         FILTER_ORDER   = 256,
  parameter int         COEF_WIDTH     = 16,
  parameter int         COEF_AWIDTH    = $clog2(FILTER_ORDER),
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_val_i,
  output logic                   byte_rdy_o,
  output logic                   coef_we_o,
  output logic [COEF_AWIDTH-1:0] coef_addr_o,
  output logic [COEF_WIDTH-1:0]  coef_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  load_state_e state_q, state_d;
  logic [COEF_AWIDTH-1:0] addr_q, addr_d, caddr_q, caddr_d;
  logic [COEF_WIDTH-1:0] cdata_q, cdata_d, word;
  logic [7:0] csum_q, csum_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [1:0] err_q, err_d;
  logic we_q, we_d, accept, clr, word_val, timed_out;
  assign accept = byte_val_i && byte_rdy_o;
  assign byte_rdy_o = state_q == IDLE || state_q == PAYLOAD || state_q == CSUM;
  assign busy_o = state_q == PAYLOAD || state_q == CSUM;
  assign done_o = state_q == DONE;
  assign err_o = err_q;
  assign coef_we_o = we_q;
  assign coef_addr_o = caddr_q;
  assign coef_data_o = cdata_q;
  fir_coef_assembler #(.COEF_WIDTH(COEF_WIDTH)) u_asm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr),
    .byte_val_i(accept && state_q == PAYLOAD),
    .byte_i    (byte_i),
    .word_val_o(word_val),
    .word_o    (word)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    csum_d = csum_q;
    idle_d = idle_q;
    err_d = ERR_NONE;
    we_d = 1'b0;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    clr = 1'b0;
    timed_out = !accept && idle_q + 1'b1 == TW'(TIMEOUT_CYCLES);
    case (state_q)
      IDLE: if (accept && byte_i == SYNC_BYTE) begin
        state_d = PAYLOAD;
        addr_d = '0;
        csum_d = '0;
        idle_d = '0;
        clr = 1'b1;
      end
      PAYLOAD, CSUM: begin
        idle_d = accept ? '0 : idle_q + 1'b1;
        if (timed_out) begin
          state_d = ERROR;
          err_d = ERR_TIMEOUT;
        end else if (accept && state_q == CSUM) begin
          state_d = byte_i == csum_q ? DONE : ERROR;
          err_d = byte_i == csum_q ? ERR_NONE : ERR_CSUM;
        end else if (accept) begin
          csum_d = csum_q + byte_i;
          if (word_val) begin
            we_d = 1'b1;
            caddr_d = addr_q;
            cdata_d = word;
            addr_d = addr_q + 1'b1;
            state_d = addr_q == COEF_AWIDTH'(FILTER_ORDER - 1) ? CSUM : PAYLOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      csum_q <= '0;
      idle_q <= '0;
      err_q <= ERR_NONE;
      we_q <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      csum_q <= csum_d;
      idle_q <= idle_d;
      err_q <= err_d;
      we_q <= we_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end
endmodule
